// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl
// ------------
// Sequencing controller placed in front of a small single-port SRAM. After
// start it collects exactly DEPTH words from a valid/ready input stream and
// writes them to addresses 0..DEPTH-1. It then reads the same locations back
// in order and presents them on a valid/ready output stream. The SRAM is
// expected to present read data combinationally whenever mem_we is low.
//
// DEPTH must equal 2**ADDR_W so that the address counter wraps exactly at
// the end of a burst.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a burst (only looked at while idle)
//   in_valid   in   input word valid
//   in_data    in   input word
//   in_ready   out  input word accepted this cycle (high while writing)
//   mem_we     out  SRAM write enable (registered)
//   mem_addr   out  SRAM address (registered)
//   mem_din    out  SRAM write data (registered)
//   mem_dout   in   SRAM read data, combinational from mem_addr
//   out_valid  out  read-back word valid
//   out_data   out  read-back word
//   out_ready  in   downstream accepts the read-back word
//   busy       out  a burst is in progress
//   done       out  one-cycle pulse after the last word has been handed off
module mem_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Index of the last word in a burst, at the width of each counter that
  // gets compared against it.
  localparam logic [ADDR_W:0]   LAST_WR   = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    TURN,
    READ,
    FLUSH
  } state_t;

  state_t state;
  state_t state_next;

  // One bit wider than the address so it can count a full burst.
  logic [ADDR_W:0] wr_cnt;

  logic accept;
  logic load;
  logic finish;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the per-cycle handshake qualifiers. accept is an
  // input handshake while writing, load refills the output register while
  // reading, and finish is the hand-off of the final word from FLUSH.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (wr_cnt == LAST_WR)) begin
          state_next = TURN;
        end
      end
      TURN: begin
        // The SRAM commits the last word during this cycle.
        state_next = READ;
      end
      READ: begin
        // The output register can take a new word whenever it is empty or
        // its current word leaves this cycle.
        load = !out_valid || out_ready;
        if (load && (mem_addr == LAST_ADDR)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        finish = out_valid && out_ready;
        if (finish) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath registers. The SRAM interface is fully registered so that a
  // word accepted at one edge is driven to the SRAM during the next cycle.
  // Read data is captured straight from mem_dout while mem_we is low; the
  // TURN cycle guarantees the last write has finished before the first read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      case (state)
        IDLE: begin
          wr_cnt <= '0;
          mem_we <= 1'b0;
        end
        WRITE: begin
          if (accept) begin
            mem_we   <= 1'b1;
            mem_addr <= wr_cnt[ADDR_W-1:0];
            mem_din  <= in_data;
            wr_cnt   <= wr_cnt + 1'b1;
          end else begin
            mem_we <= 1'b0;
          end
        end
        TURN: begin
          mem_we   <= 1'b0;
          mem_addr <= '0;
        end
        READ: begin
          mem_we <= 1'b0;
          if (load) begin
            out_data  <= mem_dout;
            out_valid <= 1'b1;
            // Wraps back to 0 after the last address.
            mem_addr  <= mem_addr + 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          mem_we <= 1'b0;
          if (finish) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl
// ---------------
// Bench for mem_seq_ctrl with a behavioural SRAM attached. For every burst
// the expected waveform of each output is worked out up front from the
// burst rules (when each word is accepted, when each read-back word is
// offered and taken), then compared cycle by cycle.
module tb_mem_seq_ctrl;

  localparam int LEN = 200;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int cycle;

  // Stimulus for one burst, indexed by cycle number (cycle 0 = start cycle).
  bit         ivA    [LEN];
  bit         ordyA  [LEN];
  bit         stA    [LEN];
  logic [7:0] inDataA[LEN];
  logic [7:0] words  [8];

  // Expected outputs per cycle; eAddr of -1 means mem_addr is not checked.
  bit         eIr  [LEN];
  bit         eWe  [LEN];
  bit         eOv  [LEN];
  bit         eBusy[LEN];
  bit         eDone[LEN];
  int         eAddr[LEN];
  logic [7:0] eDin [LEN];
  logic [7:0] eOd  [LEN];
  int         dCycle;

  logic [7:0] sram [8];

  mem_seq_ctrl #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Single-port SRAM: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
  end
  assign mem_dout = sram[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  // Derive the expected waveform of one burst from its stimulus.
  task automatic buildModel();
    int acc;
    int w;
    int p;
    int c;
    for (int k = 0; k < LEN; k++) begin
      eIr[k] = 0; eWe[k] = 0; eOv[k] = 0; eBusy[k] = 0; eDone[k] = 0;
      eAddr[k] = -1; eDin[k] = 8'h00; eOd[k] = 8'h00;
      inDataA[k] = 8'($urandom);
    end
    eAddr[0] = 0;
    // Write phase: ready from cycle 1 until the eighth word is taken; each
    // taken word shows up on the SRAM port one cycle later.
    acc = 0;
    w = 0;
    for (int k = 1; acc < 8; k++) begin
      eIr[k] = 1;
      inDataA[k] = words[acc];
      if (ivA[k]) begin
        eWe[k+1]   = 1;
        eAddr[k+1] = acc;
        eDin[k+1]  = words[acc];
        acc++;
        if (acc == 8) w = k;
      end
    end
    // One turnaround cycle, one cycle reading address 0, then word i is
    // offered until the first cycle with out_ready high.
    eAddr[w+2] = 0;
    p = w + 3;
    for (int i = 0; i < 8; i++) begin
      c = p;
      while (!ordyA[c]) c++;
      for (int t = p; t <= c; t++) begin
        eOv[t]   = 1;
        eOd[t]   = words[i];
        eAddr[t] = (i + 1) % 8;
      end
      p = c + 1;
    end
    dCycle = p;
    for (int k = 1; k < dCycle; k++) eBusy[k] = 1;
    eDone[dCycle] = 1;
    eAddr[dCycle] = 0;
  endtask

  // Run one burst from its start cycle up to and including its done cycle.
  // chained: start was already driven in the previous burst's done cycle.
  // chainNext: drive start in this burst's done cycle.
  task automatic applyStimulus(input bit chained, input bit chainNext);
    buildModel();
    for (int c = (chained ? 1 : 0); c <= dCycle; c++) begin
      @(negedge clk);
      cycle = c;
      checkOutput("in_ready", 32'(in_ready), 32'(eIr[c]));
      checkOutput("mem_we", 32'(mem_we), 32'(eWe[c]));
      if (eAddr[c] >= 0) checkOutput("mem_addr", 32'(mem_addr), 32'(eAddr[c]));
      if (eWe[c]) checkOutput("mem_din", 32'(mem_din), 32'(eDin[c]));
      checkOutput("out_valid", 32'(out_valid), 32'(eOv[c]));
      if (eOv[c]) checkOutput("out_data", 32'(out_data), 32'(eOd[c]));
      checkOutput("busy", 32'(busy), 32'(eBusy[c]));
      checkOutput("done", 32'(done), 32'(eDone[c]));
      start     = (c == 0) ? 1'b1 : ((c == dCycle) ? chainNext : stA[c]);
      in_valid  = ivA[c];
      in_data   = inDataA[c];
      out_ready = ordyA[c];
    end
  endtask

  task automatic setFull();
    for (int k = 0; k < LEN; k++) begin
      ivA[k] = 1; ordyA[k] = 1; stA[k] = 0;
    end
  endtask

  task automatic setRandom();
    for (int k = 0; k < LEN; k++) begin
      ivA[k]   = (k >= 60)  || ($urandom_range(0, 3) != 0);
      ordyA[k] = (k >= 100) || ($urandom_range(0, 2) != 0);
      stA[k]   = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Start a burst, let a few words in, then pull reset between clock edges.
  task automatic resetMidBurst();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 8'hC1 + 8'(k);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cycle = -1;
    checkResetValues("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit chainFlag;
    bit nextFlag;
    checks = 0;
    errors = 0;
    cycle = -1;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) sram[i] = 8'h00;

    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Full throughput, 0x11..0x88.
    setFull();
    for (int i = 0; i < 8; i++) words[i] = 8'h11 * 8'(i + 1);
    applyStimulus(1'b0, 1'b0);

    // Input gaps: in_valid 1,0,1,0,... from cycle 1, data 0xA0..0xA7.
    setFull();
    for (int k = 0; k < LEN; k++) ivA[k] = (k % 2) == 1;
    for (int i = 0; i < 8; i++) words[i] = 8'hA0 + 8'(i);
    applyStimulus(1'b0, 1'b0);

    // Output stall: word 2 (0x33) is offered from cycle 13; hold it 3 cycles.
    setFull();
    for (int i = 0; i < 8; i++) words[i] = 8'h31 + 8'(i);
    ordyA[13] = 0; ordyA[14] = 0; ordyA[15] = 0;
    applyStimulus(1'b0, 1'b0);

    // Start pulsed every cycle of the burst, then restarted in the done
    // cycle; second burst overwrites the same addresses with new data.
    setFull();
    for (int k = 0; k < LEN; k++) stA[k] = 1;
    for (int i = 0; i < 8; i++) words[i] = 8'(i);
    applyStimulus(1'b0, 1'b1);
    setFull();
    for (int i = 0; i < 8; i++) words[i] = 8'hF8 + 8'(i);
    applyStimulus(1'b1, 1'b0);

    // Reset mid-burst, then a fresh burst from address 0.
    resetMidBurst();
    setRandom();
    applyStimulus(1'b0, 1'b0);

    // Randomized bursts, sometimes back-to-back.
    chainFlag = 1'b0;
    for (int b = 0; b < 8; b++) begin
      setRandom();
      nextFlag = (b < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(chainFlag, nextFlag);
      chainFlag = nextFlag;
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
